adder_rr_scheduler: RTL

Round-robin scheduler sharing one 2-bit carry-look-ahead add datapath and its 7-segment BCD display between NREQ requesters. Each requester presents an operand pair and raises a request. The block grants one requester at a time, latches its operands and computes the sum. It then holds the result on the display for a programmable number of cycles, signals completion and moves on. It sits between the board switch/requester logic and the seven-segment display driver.

---
 rtl/adder_rr_scheduler.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/adder_rr_scheduler.sv
// Round-robin scheduler sharing one W-bit carry-look-ahead adder and a 7-segment BCD display.
// Define XACT_COUNT_EN to add the 8-bit completed-transaction counter output xact_cnt.
module adder_rr_scheduler #(
    parameter int NREQ        = 4,
    parameter int W           = 2,
    parameter int HOLD_CYCLES = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] a_in,
    input  logic [NREQ*W-1:0] b_in,
    output logic [NREQ-1:0]   gnt,
    output logic [2:0]        owner,
    output logic              busy,
    output logic [W:0]        sum_out,
    output logic              done,
`ifdef XACT_COUNT_EN
    output logic [7:0]        xact_cnt,
`endif
    output logic [6:0]        seg
);

    // state | meaning
    // IDLE  | waiting for a request; grant, owner and operand latch on the accepting edge
    // ADD   | one cycle: register the look-ahead sum and its display code, load hold timer
    // HOLD  | result on display; timer counts down, terminal count pulses done

    localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [NREQ-1:0] gnt_d;
    logic [2:0]      owner_d;
    logic [2:0]      last_q, last_d;
    logic [W-1:0]    a_lat, a_lat_d;
    logic [W-1:0]    b_lat, b_lat_d;
    logic [W:0]      sum_d;
    logic [6:0]      seg_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            done_d;

    logic [7:0]      req_ext;
    logic [2:0]      cand;
    logic [2:0]      pick_idx;
    logic            pick_found;
    logic [W-1:0]    a_sel, b_sel;

    logic [W-1:0]    g, p;
    logic [W:0]      c;
    logic [W:0]      sum_cla;

    function automatic logic [6:0] seg_dec(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    assign req_ext = 8'(req);

    // Search starts just past the last served requester, so it gets lowest priority.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = 3'((int'(last_q) + i) % NREQ);
            if (!pick_found && req_ext[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (3'(i) == pick_idx) begin
                a_sel = a_in[i*W +: W];
                b_sel = b_in[i*W +: W];
            end
        end
    end

    always_comb begin
        g    = a_lat & b_lat;
        p    = a_lat ^ b_lat;
        c    = '0;
        for (int i = 0; i < W; i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
        end
        sum_cla = {c[W], p ^ c[W-1:0]};
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt;
        owner_d = owner;
        last_d  = last_q;
        a_lat_d = a_lat;
        b_lat_d = b_lat;
        sum_d   = sum_out;
        seg_d   = seg;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    for (int i = 0; i < NREQ; i++) begin
                        gnt_d[i] = (3'(i) == pick_idx);
                    end
                    owner_d = pick_idx;
                    a_lat_d = a_sel;
                    b_lat_d = b_sel;
                    state_d = ADD;
                end
            end
            ADD: begin
                sum_d   = sum_cla;
                seg_d   = seg_dec(4'(sum_cla));
                cnt_d   = CW'(HOLD_CYCLES - 1);
                state_d = HOLD;
            end
            HOLD: begin
                if (cnt_q == '0) begin
                    done_d  = 1'b1;
                    gnt_d   = '0;
                    last_d  = owner;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt     <= '0;
            owner   <= '0;
            last_q  <= 3'(NREQ - 1);
            a_lat   <= '0;
            b_lat   <= '0;
            sum_out <= '0;
            seg     <= 7'b1111111;
            cnt_q   <= '0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt     <= gnt_d;
            owner   <= owner_d;
            last_q  <= last_d;
            a_lat   <= a_lat_d;
            b_lat   <= b_lat_d;
            sum_out <= sum_d;
            seg     <= seg_d;
            cnt_q   <= cnt_d;
            done    <= done_d;
        end
    end

    assign busy = (state_q != IDLE);

`ifdef XACT_COUNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xact_cnt <= '0;
        end else if (done) begin
            xact_cnt <= xact_cnt + 8'd1;
        end
    end
`endif

endmodule
